mux_tree_pipe: RTL and testbench



---
 rtl/mux_tree_pipe.sv | 119 +++++++++++
 tb/tb_mux_tree_pipe.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_tree_pipe.sv
// mux_tree_pipe: N-to-1 selector of W-bit channels built as a binary tree of
// 2:1 stages, with optional per-level registers and valid/ready flow control.
module mux_tree_pipe #(
    parameter int N    = 5,
    parameter int W    = 1,
    parameter int SW   = $clog2(N),
    parameter int PIPE = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] in_data,
    input  logic [SW-1:0]  sel,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic           out_sel_err
);
    localparam int L = SW;

    function automatic int elems_at(int k);
        return (N + (1 << k) - 1) >> k;
    endfunction

    logic           adv;
    logic           sel_err;
    logic [N*W-1:0] entry_data;

    // Out-of-range beats enter with all-zero data so every tree shape yields 0.
    assign sel_err    = 32'(sel) >= N;
    assign entry_data = sel_err ? '0 : in_data;
    assign adv        = !out_valid || out_ready;
    assign in_ready   = adv;

    for (genvar k = 0; k < L; k++) begin : g_lvl
        localparam int NI = elems_at(k);
        localparam int NO = elems_at(k + 1);
        localparam int SR = SW - k;

        logic [NI*W-1:0] lv_data;
        logic [SR-1:0]   lv_sel;
        logic            lv_valid;
        logic            lv_err;
        logic [NO*W-1:0] data_d;
        logic [NO*W-1:0] o_data;
        logic            o_valid;
        logic            o_err;

        if (k == 0) begin : g_src
            assign lv_data  = entry_data;
            assign lv_sel   = sel;
            assign lv_valid = in_valid;
            assign lv_err   = sel_err;
        end else begin : g_src
            assign lv_data  = g_lvl[k-1].o_data;
            assign lv_sel   = g_lvl[k-1].g_sel.o_sel;
            assign lv_valid = g_lvl[k-1].o_valid;
            assign lv_err   = g_lvl[k-1].o_err;
        end

        // An unpaired top element skips this level's select bit.
        for (genvar j = 0; j < NO; j++) begin : g_mux
            if (2 * j + 1 < NI) begin : g_pair
                assign data_d[j*W +: W] = lv_sel[0]
                    ? lv_data[(2*j+1)*W +: W]
                    : lv_data[(2*j)*W +: W];
            end else begin : g_pass
                assign data_d[j*W +: W] = lv_data[(2*j)*W +: W];
            end
        end

        if (k < L - 1) begin : g_sel
            logic [SR-2:0] o_sel;
            if (PIPE != 0) begin : g_reg
                logic [SR-2:0] sel_q;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        sel_q <= '0;
                    end else if (adv) begin
                        sel_q <= lv_sel[SR-1:1];
                    end
                end
                assign o_sel = sel_q;
            end else begin : g_wire
                assign o_sel = lv_sel[SR-1:1];
            end
        end

        if (PIPE != 0 || k == L - 1) begin : g_stage
            logic [NO*W-1:0] data_q;
            logic            valid_q;
            logic            err_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                    err_q   <= 1'b0;
                end else if (adv) begin
                    data_q  <= data_d;
                    valid_q <= lv_valid;
                    err_q   <= lv_err;
                end
            end
            assign o_data  = data_q;
            assign o_valid = valid_q;
            assign o_err   = err_q;
        end else begin : g_comb
            assign o_data  = data_d;
            assign o_valid = lv_valid;
            assign o_err   = lv_err;
        end
    end

    assign out_valid   = g_lvl[L-1].o_valid;
    assign out_data    = g_lvl[L-1].o_data;
    assign out_sel_err = g_lvl[L-1].o_err;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// tb_mux_tree_pipe: directed and randomized checks of mux_tree_pipe over
// several N/W/PIPE configurations against an index-selection reference.
module tb_mux_tree_pipe;
    localparam int NI = 13;
    localparam int PN  [NI] = '{5, 5, 8, 2, 2, 3, 3, 5, 5, 7, 7, 16, 16};
    localparam int PW  [NI] = '{1, 8, 4, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8};
    localparam int PP  [NI] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    localparam int PSW [NI] = '{3, 3, 3, 1, 1, 2, 2, 3, 3, 3, 3, 4, 4};
    localparam int PS  [NI] = '{3, 1, 3, 1, 1, 1, 2, 1, 3, 1, 3, 1, 4};

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NI-1:0] iv;
    logic [NI-1:0] ir;
    logic [NI-1:0] ov;
    logic [NI-1:0] ordy;
    logic [NI-1:0] oe;
    logic [127:0]  idat [NI];
    logic [3:0]    isel [NI];
    logic [7:0]    odat [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int GN = PN[g];
        localparam int GW = PW[g];
        localparam int GS = PSW[g];
        logic [GW-1:0] od;
        mux_tree_pipe #(.N(GN), .W(GW), .PIPE(PP[g])) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .in_valid    (iv[g]),
            .in_ready    (ir[g]),
            .in_data     (idat[g][GN*GW-1:0]),
            .sel         (isel[g][GS-1:0]),
            .out_valid   (ov[g]),
            .out_ready   (ordy[g]),
            .out_data    (od),
            .out_sel_err (oe[g])
        );
        assign odat[g] = 8'(od);
    end

    logic [8:0]    fq_v [NI][16];
    int            fq_a [NI][16];
    int            fq_s [NI][16];
    int            wp [NI];
    int            rp [NI];
    int            pend [NI];
    int            stall [NI];
    int            nacc [NI];
    logic          hold [NI];
    logic [8:0]    held [NI];
    logic [8:0]    lg_v [NI][64];
    int            lg_c [NI][64];
    int            lg_n [NI];
    logic [NI-1:0] ovh [256];
    int            cyc;
    int            checks;
    int            errors;

    function automatic logic [8:0] ref_out(int g, logic [127:0] d,
                                           logic [3:0] s);
        logic [127:0] t;
        if (int'(s) >= PN[g]) return 9'h100;
        t = d >> (int'(s) * PW[g]);
        return {1'b0, t[7:0] & 8'((1 << PW[g]) - 1)};
    endfunction

    task automatic chk(input string tag, input int g,
                       input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s inst%0d observed %0h expected %0h",
                   tag, g, obs, exp);
        end
    endtask

    task automatic sb_clear();
        for (int g = 0; g < NI; g++) begin
            wp[g] = 0; rp[g] = 0; pend[g] = 0; stall[g] = 0;
            hold[g] = 1'b0; held[g] = '0; lg_n[g] = 0;
        end
    endtask

    task automatic lg_clear();
        for (int g = 0; g < NI; g++) lg_n[g] = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        ovh[cyc & 255] = ov;
        for (int g = 0; g < NI; g++) begin
            chk("in_ready", g, 32'(ir[g]), 32'(!ov[g] || ordy[g]));
            if (hold[g])
                chk("hold", g, {ov[g], oe[g], odat[g]}, {1'b1, held[g]});
            if (ov[g] && ordy[g]) begin
                chk("pending", g, 32'(pend[g] > 0), 32'd1);
                if (pend[g] > 0) begin
                    chk("data", g, {oe[g], odat[g]}, fq_v[g][rp[g]]);
                    chk("latency", g, cyc - fq_a[g][rp[g]],
                        PS[g] + stall[g] - fq_s[g][rp[g]]);
                    rp[g] = (rp[g] + 1) % 16;
                    pend[g]--;
                end
                if (lg_n[g] < 64) begin
                    lg_v[g][lg_n[g]] = {oe[g], odat[g]};
                    lg_c[g][lg_n[g]] = cyc;
                    lg_n[g]++;
                end
            end
            if (ov[g] && !ordy[g]) stall[g]++;
            hold[g] = ov[g] && !ordy[g];
            held[g] = {oe[g], odat[g]};
            if (iv[g] && ir[g]) begin
                fq_v[g][wp[g]] = ref_out(g, idat[g], isel[g]);
                fq_a[g][wp[g]] = cyc;
                fq_s[g][wp[g]] = stall[g];
                wp[g] = (wp[g] + 1) % 16;
                pend[g]++;
                nacc[g]++;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0]  pat;
        logic [4:0]  pv;
        logic [31:0] bd [6];
        logic [3:0]  bs [6];
        int          t0;
        int          k;
        logic        acc;
        logic        done;

        checks = 0; errors = 0; cyc = 0;
        pat = 5'b10110;
        rst_n = 1'b0;
        iv = '0;
        ordy = '1;
        for (int g = 0; g < NI; g++) begin
            idat[g] = '0; isel[g] = '0; nacc[g] = 0;
        end
        sb_clear();
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < NI; g++) begin
            chk("rst_valid", g, 32'(ov[g]), 32'd0);
            chk("rst_err", g, 32'(oe[g]), 32'd0);
            chk("rst_data", g, 32'(odat[g]), 32'd0);
            chk("rst_ready", g, 32'(ir[g]), 32'd1);
        end
        rst_n = 1'b1;
        tick();

        // N=5 W=1 PIPE=1: sweep sel 0..4 back-to-back
        lg_clear();
        t0 = cyc;
        for (int i = 0; i < 5; i++) begin
            iv[0] = 1'b1; idat[0] = 128'(pat); isel[0] = 4'(i);
            tick();
        end
        iv[0] = 1'b0;
        repeat (6) tick();
        chk("sweep_n", 0, lg_n[0], 5);
        for (int i = 0; i < 5; i++) begin
            chk("sweep_data", 0, 32'(lg_v[0][i]), {23'd0, 1'b0, 7'd0, pat[i]});
            chk("sweep_cyc", 0, lg_c[0][i], t0 + 3 + i);
        end

        // N=5 W=8 PIPE=0: out-of-range selects
        lg_clear();
        t0 = cyc;
        for (int i = 0; i < 3; i++) begin
            iv[1] = 1'b1; idat[1] = 128'({5{8'hAA}}); isel[1] = 4'(5 + i);
            tick();
        end
        iv[1] = 1'b0;
        repeat (4) tick();
        chk("err_n", 1, lg_n[1], 3);
        for (int i = 0; i < 3; i++) begin
            chk("err_data", 1, 32'(lg_v[1][i]), 32'h100);
            chk("err_cyc", 1, lg_c[1][i], t0 + 1 + i);
        end

        // N=8 W=4 PIPE=1: six beats with a four-cycle stall
        lg_clear();
        for (int i = 0; i < 6; i++) begin
            bd[i] = $urandom();
            bs[i] = 4'($urandom_range(0, 7));
        end
        k = 0;
        for (int c = 0; c < 40 && lg_n[2] < 6; c++) begin
            iv[2] = (k < 6);
            idat[2] = 128'(bd[k % 6]);
            isel[2] = bs[k % 6];
            ordy[2] = !(c >= 5 && c < 9);
            #1;
            if (c >= 5 && c < 9) chk("bp_ready", 2, 32'(ir[2]), 32'd0);
            acc = iv[2] && ir[2];
            tick();
            if (acc) k++;
        end
        iv[2] = 1'b0;
        ordy[2] = 1'b1;
        repeat (5) tick();
        chk("bp_n", 2, lg_n[2], 6);
        for (int i = 0; i < 6; i++)
            chk("bp_order", 2, 32'(lg_v[2][i]), 32'(ref_out(2, 128'(bd[i]), bs[i])));

        // Bubble pattern 1,0,1,1,0 on N=5 PIPE=1
        pv = 5'b01101;
        t0 = cyc;
        for (int i = 0; i < 5; i++) begin
            iv[0] = pv[i]; idat[0] = 128'(pat); isel[0] = 4'(i);
            tick();
        end
        iv[0] = 1'b0;
        repeat (6) tick();
        for (int i = 0; i < 3; i++)
            chk("bubble_pre", 0, 32'(ovh[(t0 + i) & 255][0]), 32'd0);
        for (int i = 0; i < 5; i++)
            chk("bubble", 0, 32'(ovh[(t0 + 3 + i) & 255][0]), 32'(pv[i]));

        // Reset with three beats in flight
        for (int i = 0; i < 3; i++) begin
            iv[0] = 1'b1; idat[0] = 128'(pat); isel[0] = 4'd2;
            tick();
        end
        chk("pre_rst_valid", 0, 32'(ov[0]), 32'd1);
        chk("pre_rst_data", 0, 32'(odat[0]), 32'd1);
        iv[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        for (int g = 0; g < NI; g++) begin
            chk("arst_valid", g, 32'(ov[g]), 32'd0);
            chk("arst_data", g, 32'(odat[g]), 32'd0);
        end
        sb_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        t0 = cyc;
        iv[0] = 1'b1; idat[0] = 128'(pat); isel[0] = 4'd4;
        tick();
        iv[0] = 1'b0;
        repeat (5) tick();
        chk("post_rst_n", 0, lg_n[0], 1);
        chk("post_rst_data", 0, 32'(lg_v[0][0]), 32'd1);
        chk("post_rst_cyc", 0, lg_c[0][0], t0 + 3);

        // Random traffic on every configuration
        for (int g = 0; g < NI; g++) nacc[g] = 0;
        for (int c = 0; c < 20000; c++) begin
            done = 1'b1;
            for (int g = 0; g < NI; g++) if (nacc[g] < 2000) done = 1'b0;
            if (done) break;
            for (int g = 0; g < NI; g++) begin
                iv[g] = (nacc[g] < 2000) && ($urandom_range(0, 3) != 0);
                ordy[g] = ($urandom_range(0, 3) != 0);
                idat[g] = {$urandom(), $urandom(), $urandom(), $urandom()};
                isel[g] = 4'($urandom_range(0, (1 << PSW[g]) - 1));
            end
            tick();
        end
        iv = '0;
        ordy = '1;
        repeat (8) tick();
        for (int g = 0; g < NI; g++) begin
            chk("rand_beats", g, 32'(nacc[g] >= 2000), 32'd1);
            chk("rand_drain", g, pend[g], 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
